// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the CPU control sequencer: FSM state encoding,
// instruction opcodes and ALU operation codes, plus the opcode-to-ALU-op
// mapping used while the ALU result is being formed.
// -----------------------------------------------------------------------------
package cpu_pkg;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_LOAD   = 4'd3,
        S_MOV    = 4'd4,
        S_LDPC   = 4'd5,
        S_BR     = 4'd6,
        S_ALU0   = 4'd7,
        S_ALU1   = 4'd8,
        S_ALU2   = 4'd9
    } state_t;

    localparam logic [3:0] OP_LOAD = 4'd0;
    localparam logic [3:0] OP_MOV  = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_LDPC = 4'd5;
    localparam logic [3:0] OP_BR   = 4'd6;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_XOR = 2'b10;

    function automatic logic [1:0] alu_code(input logic [3:0] opcode);
        case (opcode)
            OP_SUB:  return ALU_SUB;
            OP_XOR:  return ALU_XOR;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/cpu_sequencer_dec3to8.sv
// -----------------------------------------------------------------------------
// dec3to8
// 3-bit index to one-hot 8-bit decoder with enable. Used for the register
// file write enables and bus-drive selects.
// Ports:
//   sel_i    3-bit register index
//   en_i     enable; output is all zero when low
//   onehot_o one-hot select (at most one bit set)
// -----------------------------------------------------------------------------
module dec3to8 (
    input  logic [2:0] sel_i,
    input  logic       en_i,
    output logic [7:0] onehot_o
);

    always_comb begin
        onehot_o = '0;
        if (en_i) begin
            onehot_o[sel_i] = 1'b1;
        end
    end

endmodule

// File: rtl/cpu_sequencer.sv
// -----------------------------------------------------------------------------
// cpu_sequencer
// Multi-cycle control FSM for a small bus-based CPU. Fetches 16-bit
// instructions, decodes opcode/rx/ry and sequences the datapath control
// strobes one state per cycle. Outputs are decoded from the registered state
// and instruction register (plus instr_valid while fetching).
// Ports:
//   clk, resetn          clock, asynchronous active-low reset
//   run                  fetch/execute enable (sampled in IDLE and final states)
//   instr, instr_valid   instruction word and its valid qualifier
//   instr_req            fetch request (FETCH state)
//   ir_load, pc_inc      capture instruction / advance PC on accepted fetch
//   r_in, r_out          one-hot register write enable / bus drive
//   din_out, pc_out,
//   g_out                bus drivers for DIN, PC and ALU result G
//   pc_load              load PC from bus (branch)
//   a_in, g_in, alu_op   ALU operand/result capture and operation select
//   done, illegal        one-cycle retire / illegal-opcode pulses
//   busy                 sequencer not idle
//   retired              retired-instruction count (wraps)
// -----------------------------------------------------------------------------
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             run,
    input  logic [15:0]      instr,
    input  logic             instr_valid,
    output logic             instr_req,
    output logic             ir_load,
    output logic [7:0]       r_in,
    output logic [7:0]       r_out,
    output logic             din_out,
    output logic             pc_out,
    output logic             pc_load,
    output logic             pc_inc,
    output logic             a_in,
    output logic             g_in,
    output logic             g_out,
    output logic [1:0]       alu_op,
    output logic             done,
    output logic             illegal,
    output logic             busy,
    output logic [CNT_W-1:0] retired
);

    state_t             state_q, state_d;
    state_t             end_next;
    logic [15:0]        ir_q;
    logic [CNT_W-1:0]   retired_q;

    logic [3:0]         opcode;
    logic [2:0]         rx, ry;
    logic               rin_en, rout_en;
    logic [2:0]         rin_sel, rout_sel;

    // Low instruction bits are don't-care for this instruction set.
    logic               unused_ir_bits;
    assign unused_ir_bits = ^ir_q[5:0];

    assign opcode = ir_q[15:12];
    assign rx     = ir_q[11:9];
    assign ry     = ir_q[8:6];

    // Where every final state (and an illegal decode) goes next.
    assign end_next = run ? S_FETCH : S_IDLE;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            ir_q      <= '0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (ir_load) begin
                ir_q <= instr;
            end
            if (done) begin
                retired_q <= retired_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        instr_req = 1'b0;
        ir_load   = 1'b0;
        pc_inc    = 1'b0;
        din_out   = 1'b0;
        pc_out    = 1'b0;
        pc_load   = 1'b0;
        a_in      = 1'b0;
        g_in      = 1'b0;
        g_out     = 1'b0;
        alu_op    = ALU_ADD;
        done      = 1'b0;
        illegal   = 1'b0;
        rin_en    = 1'b0;
        rin_sel   = rx;
        rout_en   = 1'b0;
        rout_sel  = rx;

        case (state_q)
            S_IDLE: begin
                if (run) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                instr_req = 1'b1;
                if (instr_valid) begin
                    ir_load = 1'b1;
                    pc_inc  = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_LOAD:                state_d = S_LOAD;
                    OP_MOV:                 state_d = S_MOV;
                    OP_ADD, OP_SUB, OP_XOR: state_d = S_ALU0;
                    OP_LDPC:                state_d = S_LDPC;
                    OP_BR:                  state_d = S_BR;
                    default: begin
                        // Unknown opcode: flag it and drop the instruction.
                        illegal = 1'b1;
                        state_d = end_next;
                    end
                endcase
            end
            S_LOAD: begin
                din_out = 1'b1;
                rin_en  = 1'b1;
                done    = 1'b1;
                state_d = end_next;
            end
            S_MOV: begin
                rout_en  = 1'b1;
                rout_sel = ry;
                rin_en   = 1'b1;
                done     = 1'b1;
                state_d  = end_next;
            end
            S_LDPC: begin
                pc_out  = 1'b1;
                rin_en  = 1'b1;
                done    = 1'b1;
                state_d = end_next;
            end
            S_BR: begin
                rout_en = 1'b1;
                pc_load = 1'b1;
                done    = 1'b1;
                state_d = end_next;
            end
            S_ALU0: begin
                rout_en = 1'b1;
                a_in    = 1'b1;
                state_d = S_ALU1;
            end
            S_ALU1: begin
                rout_en  = 1'b1;
                rout_sel = ry;
                g_in     = 1'b1;
                alu_op   = alu_code(opcode);
                state_d  = S_ALU2;
            end
            S_ALU2: begin
                g_out   = 1'b1;
                rin_en  = 1'b1;
                done    = 1'b1;
                state_d = end_next;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    dec3to8 u_dec_rin (
        .sel_i    (rin_sel),
        .en_i     (rin_en),
        .onehot_o (r_in)
    );

    dec3to8 u_dec_rout (
        .sel_i    (rout_sel),
        .en_i     (rout_en),
        .onehot_o (r_out)
    );

    assign busy    = (state_q != S_IDLE);
    assign retired = retired_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_cpu_sequencer
// Scoreboard bench for cpu_sequencer. The driver issues instructions and a
// reference model pushes, per instruction, the control strobes expected in
// each active cycle (cycle offset from the fetch, expected retired count).
// A monitor on the falling edge pops and compares whenever the DUT shows any
// strobe other than a bare fetch request.
// -----------------------------------------------------------------------------
module tb_cpu_sequencer;

    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             resetn;
    logic             run;
    logic [15:0]      instr;
    logic             instr_valid;
    logic             instr_req, ir_load, din_out, pc_out, pc_load, pc_inc;
    logic             a_in, g_in, g_out, done, illegal, busy;
    logic [7:0]       r_in, r_out;
    logic [1:0]       alu_op;
    logic [CNT_W-1:0] retired;

    always #5 clk = ~clk;

    cpu_sequencer #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .run         (run),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_req   (instr_req),
        .ir_load     (ir_load),
        .r_in        (r_in),
        .r_out       (r_out),
        .din_out     (din_out),
        .pc_out      (pc_out),
        .pc_load     (pc_load),
        .pc_inc      (pc_inc),
        .a_in        (a_in),
        .g_in        (g_in),
        .g_out       (g_out),
        .alu_op      (alu_op),
        .done        (done),
        .illegal     (illegal),
        .busy        (busy),
        .retired     (retired)
    );

    typedef struct packed {
        logic       instr_req, ir_load, pc_inc, din_out, pc_out, pc_load;
        logic       a_in, g_in, g_out, done, illegal;
        logic [1:0] alu_op;
        logic [7:0] r_in, r_out;
    } outs_t;

    typedef struct {
        outs_t            outs;
        int               ofs;
        logic [CNT_W-1:0] ret;
    } exp_t;

    exp_t             expq[$];
    logic [CNT_W-1:0] mdl_cnt = '0;
    int               n_chk = 0;
    int               n_pass = 0;
    bit               mon_en = 1'b0;
    bit               idle_chk = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    endtask

    function automatic outs_t sample();
        outs_t s;
        s.instr_req = instr_req; s.ir_load = ir_load; s.pc_inc = pc_inc;
        s.din_out = din_out; s.pc_out = pc_out; s.pc_load = pc_load;
        s.a_in = a_in; s.g_in = g_in; s.g_out = g_out;
        s.done = done; s.illegal = illegal; s.alu_op = alu_op;
        s.r_in = r_in; s.r_out = r_out;
        return s;
    endfunction

    task automatic push(input outs_t o, input int ofs);
        exp_t e;
        e.outs = o; e.ofs = ofs; e.ret = mdl_cnt;
        expq.push_back(e);
        if (o.done) mdl_cnt = mdl_cnt + 1'b1;
    endtask

    // Reference model: active-cycle schedule of one instruction, offset 0
    // being the cycle in which the fetch is accepted.
    task automatic model(input logic [15:0] w);
        logic [3:0] op;
        logic [2:0] rx, ry;
        outs_t      o;
        op = w[15:12]; rx = w[11:9]; ry = w[8:6];
        o = '0; o.instr_req = 1'b1; o.ir_load = 1'b1; o.pc_inc = 1'b1;
        push(o, 0);
        o = '0;
        if (op == 0) begin
            o.din_out = 1'b1; o.r_in = 8'd1 << rx; o.done = 1'b1; push(o, 2);
        end else if (op == 1) begin
            o.r_out = 8'd1 << ry; o.r_in = 8'd1 << rx; o.done = 1'b1; push(o, 2);
        end else if (op == 5) begin
            o.pc_out = 1'b1; o.r_in = 8'd1 << rx; o.done = 1'b1; push(o, 2);
        end else if (op == 6) begin
            o.r_out = 8'd1 << rx; o.pc_load = 1'b1; o.done = 1'b1; push(o, 2);
        end else if (op >= 2 && op <= 4) begin
            o.r_out = 8'd1 << rx; o.a_in = 1'b1; push(o, 2);
            o = '0;
            o.r_out = 8'd1 << ry; o.g_in = 1'b1;
            o.alu_op = (op == 3) ? 2'b01 : (op == 4) ? 2'b10 : 2'b00;
            push(o, 3);
            o = '0;
            o.g_out = 1'b1; o.r_in = 8'd1 << rx; o.done = 1'b1; push(o, 4);
        end else begin
            o.illegal = 1'b1; push(o, 1);
        end
    endtask

    // Monitor / scoreboard.
    initial begin
        int    cyc = 0;
        int    fetch_cyc = 0;
        outs_t o, m;
        exp_t  e;
        forever begin
            @(negedge clk);
            cyc++;
            if (mon_en) begin
                if (idle_chk) begin
                    chk("busy_after_stop", 64'(busy), 64'd0);
                    idle_chk = 1'b0;
                end
                o = sample();
                m = o; m.instr_req = 1'b0;
                if (m != '0) begin
                    if (o.ir_load) fetch_cyc = cyc;
                    if (expq.size() == 0) begin
                        chk("unexpected_action", 64'(o), 64'd0);
                    end else begin
                        e = expq.pop_front();
                        chk("ctrl", 64'(o), 64'(e.outs));
                        chk("cycle_ofs", 64'(cyc - fetch_cyc), 64'(e.ofs));
                        chk("retired", 64'(retired), 64'(e.ret));
                    end
                    if ((o.done || o.illegal) && !run) idle_chk = 1'b1;
                end
            end
        end
    end

    // Wait for a fetch request, optionally stall, then present one instruction.
    // drop_at > 0 lowers run that many cycles after the fetch and raises it later.
    task automatic issue(input logic [15:0] w, input int waitk, input int drop_at);
        int          t = 0;
        logic [31:0] r;
        while (!instr_req && t < 50) begin
            @(posedge clk); #1; t++;
        end
        chk("fetch_req", 64'(instr_req), 64'd1);
        for (int i = 0; i < waitk; i++) begin
            r = $urandom(); instr = r[15:0];
            @(posedge clk); #1;
            chk("req_held", 64'(instr_req), 64'd1);
        end
        instr = w; instr_valid = 1'b1;
        model(w);
        for (int i = 1; i <= ((drop_at == 0) ? 1 : 8); i++) begin
            @(posedge clk); #1;
            if (i == 1) begin
                instr_valid = 1'b0; r = $urandom(); instr = r[15:0];
            end
            if (i == drop_at) run = 1'b0;
        end
        run = 1'b1;
    endtask

    task automatic drain();
        int t = 0;
        while (expq.size() != 0 && t < 30) begin
            @(posedge clk); #1; t++;
        end
        chk("drain", 64'(expq.size()), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        logic [3:0]  op;
        resetn = 1'b0; run = 1'b0; instr = '0; instr_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outs", 64'(sample()), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_retired", 64'(retired), 64'd0);
        resetn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_no_run", 64'(busy), 64'd0);
        mon_en = 1'b1;
        run = 1'b1;

        issue(16'h0000, 0, 0);      // load r0
        issue(16'h2640, 0, 0);      // add r3,r1
        issue(16'h7000, 0, 0);      // illegal
        issue(16'h16C0, 5, 0);      // mov r3,r3 after a 5-cycle fetch stall
        issue(16'h3280, 0, 3);      // sub r1,r2 with run dropped in ALU1
        drain();
        chk("retired_dir", 64'(retired), 64'(mdl_cnt));

        for (int n = 0; n < 200; n++) begin
            r  = $urandom();
            op = 4'($urandom_range(0, 9));
            issue({op, r[11:0]}, $urandom_range(0, 2),
                  ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0);
        end
        drain();
        chk("retired_rand", 64'(retired), 64'(mdl_cnt));

        // Reset in the middle of a sub, while in ALU1.
        issue(16'h3280, 0, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("alu1_g_in", 64'(g_in), 64'd1);
        mon_en = 1'b0;
        resetn = 1'b0;
        #1;
        chk("midrst_outs", 64'(sample()), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_retired", 64'(retired), 64'd0);
        expq.delete();
        mdl_cnt = '0;
        idle_chk = 1'b0;
        @(posedge clk); #1;
        chk("midrst_no_done", 64'(done), 64'd0);
        resetn = 1'b1;
        mon_en = 1'b1;
        issue(16'h0A00, 0, 0);      // load r5
        drain();
        chk("retired_after_rst", 64'(retired), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
